// File: rtl/branch_resolve_unit.sv
// EX-stage branch/JAL/JALR resolution with a registered redirect and a 2-bit BHT for IF prediction.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int unsigned BHT_IDX_BITS = 6,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            cmp_result,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam int unsigned IDX_LSB     = 2;
    localparam int unsigned IDX_MSB     = BHT_IDX_BITS + IDX_LSB - 1;

    logic [1:0]              bht [BHT_ENTRIES];
    logic [BHT_IDX_BITS-1:0] if_idx;
    logic [BHT_IDX_BITS-1:0] ex_idx;
    logic                    resolve;
    logic                    is_cond;
    logic                    mispredict;
    logic [XLEN-1:0]         actual_next_pc;
    logic [XLEN-1:0]         tgt_pc;
    logic [XLEN-1:0]         jalr_pc;
    logic [XLEN-1:0]         seq_pc;

    // Prediction is only a hint; mispredict is judged purely on the fetched target.
    logic unused_ok;
    assign unused_ok = ^{if_pc[XLEN-1:IDX_MSB+1], if_pc[IDX_LSB-1:0], ex_pred_taken};

    assign if_idx        = if_pc[IDX_MSB:IDX_LSB];
    assign ex_idx        = ex_pc[IDX_MSB:IDX_LSB];
    assign if_pred_taken = bht[if_idx][1];

    // Resolution: jalr > jal > branch when flags illegally overlap.
    always_comb begin
        tgt_pc         = ex_pc + ex_imm;
        jalr_pc        = (ex_rs1 + ex_imm) & ~XLEN'(1);
        seq_pc         = ex_pc + XLEN'(4);
        actual_next_pc = seq_pc;
        is_cond        = 1'b0;
        if (ex_is_jalr) begin
            actual_next_pc = jalr_pc;
        end else if (ex_is_jal) begin
            actual_next_pc = tgt_pc;
        end else if (ex_is_branch) begin
            is_cond        = 1'b1;
            actual_next_pc = cmp_result ? tgt_pc : seq_pc;
        end
        resolve    = ex_valid & ~stall & ~redirect_valid
                   & (ex_is_branch | ex_is_jal | ex_is_jalr);
        mispredict = (actual_next_pc != ex_pred_target);
    end

    // Redirect register: one-cycle pulse after a mispredicting resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= resolve & mispredict;
            if (resolve && mispredict) begin
                redirect_pc <= actual_next_pc;
            end
        end
    end

    // BHT: saturating 2-bit counters, trained only by conditional branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve && is_cond) begin
            if (cmp_result) begin
                if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else begin
                if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (resolve) begin
            if (perf_branches != 32'hFFFF_FFFF) perf_branches <= perf_branches + 32'd1;
            if (mispredict && perf_mispredicts != 32'hFFFF_FFFF) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && ex_valid) begin
            assert ($onehot0({ex_is_branch, ex_is_jal, ex_is_jalr}))
                else $error("branch_resolve_unit: multiple control-transfer type flags set");
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a behavioural reference model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_pred_target, if_pc;
    logic        cmp_result, ex_pred_taken;
    logic        if_pred_taken, redirect_valid;
    logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    int unsigned m_bht [64];
    bit          m_rv;
    logic [31:0] m_rpc;
    longint      m_br, m_mp;

    branch_resolve_unit #(.BHT_IDX_BITS(6), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .cmp_result(cmp_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .perf_branches(perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic [31:0] ref_next(input bit br, input bit jal, input bit jalr,
                                             input logic [31:0] pc, input logic [31:0] imm,
                                             input logic [31:0] rs1, input bit cmp);
        if (jalr) return (rs1 + imm) & 32'hFFFF_FFFE;
        if (jal)  return pc + imm;
        if (br && cmp) return pc + imm;
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_rv = 0; m_rpc = '0; m_br = 0; m_mp = 0;
    endtask

    // One clock: check lookup before the edge, then registered outputs after it.
    task automatic cycle();
        bit          res;
        logic [31:0] nxt;
        @(negedge clk);
        check("if_pred_taken", 32'(if_pred_taken), (m_bht[bidx(if_pc)] >= 2) ? 32'd1 : 32'd0);
        res = ex_valid && !stall && !m_rv && (ex_is_branch || ex_is_jal || ex_is_jalr);
        nxt = ref_next(ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm, ex_rs1, cmp_result);
        @(posedge clk);
        #1;
        if (res) begin
            m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
            m_rv = (nxt != ex_pred_target);
            if (m_rv) begin
                m_rpc = nxt;
                m_mp  = (m_mp < 64'hFFFF_FFFF) ? m_mp + 1 : m_mp;
            end
            if (ex_is_branch && !ex_is_jal && !ex_is_jalr) begin
                if (cmp_result) m_bht[bidx(ex_pc)] = (m_bht[bidx(ex_pc)] == 3) ? 3 : m_bht[bidx(ex_pc)] + 1;
                else            m_bht[bidx(ex_pc)] = (m_bht[bidx(ex_pc)] == 0) ? 0 : m_bht[bidx(ex_pc)] - 1;
            end
        end else begin
            m_rv = 0;
        end
        check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
`ifdef BRU_PERF_CNT_EN
        check("perf_branches", perf_branches, m_br[31:0]);
        check("perf_mispredicts", perf_mispredicts, m_mp[31:0]);
`else
        check("perf_branches_tied", perf_branches, 32'd0);
        check("perf_mispredicts_tied", perf_mispredicts, 32'd0);
`endif
    endtask

    task automatic issue(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input bit cmp, input logic [31:0] tgt,
                         input bit stl, input logic [31:0] ipc);
        ex_valid       = (kind != 0);
        ex_is_branch   = (kind == 1);
        ex_is_jal      = (kind == 2);
        ex_is_jalr     = (kind == 3);
        ex_pc          = pc;
        ex_imm         = imm;
        ex_rs1         = rs1;
        cmp_result     = cmp;
        ex_pred_target = tgt;
        ex_pred_taken  = (tgt != pc + 32'd4);
        stall          = stl;
        if_pc          = ipc;
        cycle();
    endtask

    task automatic idle(input logic [31:0] ipc);
        issue(0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, ipc);
    endtask

    initial begin
        int          kind;
        logic [31:0] pc, imm, rs1, tgt, ipc;
        bit          cmp, stl;

        rst_n = 1'b0;
        stall = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_pc = 0; ex_imm = 0; ex_rs1 = 0; cmp_result = 0; ex_pred_taken = 0;
        ex_pred_target = 0; if_pc = 32'h40;
        model_reset();
        #12;
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_pred_0x40", 32'(if_pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(32'h40);
        idle(32'h1234_5678);

        // BEQ taken, predicted not taken
        issue(1, 32'h100, 32'h20, 32'h0, 1'b1, 32'h104, 1'b0, 32'h100);
        check("beq_redirect_pc", redirect_pc, 32'h120);
        idle(32'h100);

        // JALR target bit 0 cleared
        issue(3, 32'h500, 32'h4, 32'h2003, 1'b0, 32'h2006, 1'b0, 32'h500);
        check("jalr_ok_no_redirect", 32'(redirect_valid), 32'd0);
        issue(3, 32'h500, 32'h4, 32'h2003, 1'b0, 32'h2000, 1'b0, 32'h500);
        check("jalr_redirect_pc", redirect_pc, 32'h2006);
        idle(32'h500);

        // Back-to-back mispredicts: the shadow one is squashed
        issue(1, 32'h300, 32'h8, 32'h0, 1'b1, 32'h304, 1'b0, 32'h300);
        issue(1, 32'h340, 32'h8, 32'h0, 1'b1, 32'h344, 1'b0, 32'h340);
        check("shadow_squashed", 32'(redirect_valid), 32'd0);
        idle(32'h340);

        // Saturation at 11, then one not-taken keeps prediction taken
        for (int i = 0; i < 4; i++) issue(1, 32'h200, 32'h40, 32'h0, 1'b1, 32'h240, 1'b0, 32'h200);
        idle(32'h200);
        issue(1, 32'h200, 32'h40, 32'h0, 1'b0, 32'h204, 1'b0, 32'h200);
        idle(32'h200);
        check("sat_still_taken", 32'(if_pred_taken), 32'd1);

        // Wrap-around target, then the same under stall
        issue(1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 32'hFFFF_FFF4, 1'b0, 32'hFFFF_FFF0);
        check("wrap_redirect_pc", redirect_pc, 32'h0000_0010);
        idle(32'hFFFF_FFF0);
        issue(1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 32'hFFFF_FFF4, 1'b1, 32'hFFFF_FFF0);
        check("stall_no_redirect", 32'(redirect_valid), 32'd0);
        idle(32'hFFFF_FFF0);

        // Redirect asserted during stall still drops after one cycle
        issue(2, 32'h600, 32'h100, 32'h0, 1'b0, 32'h604, 1'b0, 32'h600);
        issue(0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h600);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 7);
            kind = (kind > 3) ? 1 : kind;
            pc   = ($urandom_range(0, 1) != 0) ? (32'h1000 + 32'($urandom_range(0, 7)) * 4) : $urandom;
            imm  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
            rs1  = $urandom;
            cmp  = $urandom_range(0, 1) != 0;
            stl  = $urandom_range(0, 7) == 0;
            case ($urandom_range(0, 3))
                0, 1:    tgt = ref_next(kind == 1, kind == 2, kind == 3, pc, imm, rs1, cmp);
                2:       tgt = pc + 32'd4;
                default: tgt = $urandom;
            endcase
            ipc = ($urandom_range(0, 1) != 0) ? (32'h1000 + 32'($urandom_range(0, 7)) * 4) : $urandom;
            issue(kind, pc, imm, rs1, cmp, tgt, stl, ipc);
        end

        // Reset mid-operation cancels a pending redirect and reinitialises the BHT
        for (int i = 0; i < 3; i++) issue(1, 32'h700, 32'h10, 32'h0, 1'b1, 32'h710, 1'b0, 32'h700);
        issue(1, 32'h700, 32'h10, 32'h0, 1'b1, 32'h704, 1'b0, 32'h700);
        check("pre_reset_redirect", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_cancels_redirect", 32'(redirect_valid), 32'd0);
        check("reset_bht_reinit", 32'(if_pred_taken), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(32'h700);
        issue(1, 32'h700, 32'h10, 32'h0, 1'b0, 32'h704, 1'b0, 32'h700);
        idle(32'h700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the branch comparator's result bit in the RV32I pipeline.
- Resolves conditional branches, JAL and JALR, and computes the actual next PC.
- Detects mispredictions against the IF-stage prediction and issues a registered redirect/flush.
- Owns the 2-bit branch history table (BHT) that supplies IF's taken/not-taken prediction.

Parameters:
BHT_IDX_BITS, 6, log2 of BHT entries (64); index = pc[BHT_IDX_BITS+1:2]
XLEN, 32, datapath width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; suppresses resolution and BHT update
ex_valid  in  1  EX holds a real instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_is_jal  in  1  EX instruction is JAL
ex_is_jalr  in  1  EX instruction is JALR
ex_pc  in  XLEN  PC of EX instruction
ex_imm  in  XLEN  sign-extended immediate
ex_rs1  in  XLEN  forwarded rs1 value (JALR base)
cmp_result  in  1  branch condition result from comparator
ex_pred_taken  in  1  prediction IF made for this instruction
ex_pred_target  in  XLEN  next PC IF fetched after this instruction
if_pc  in  XLEN  current fetch PC, BHT lookup address
if_pred_taken  out  1  BHT prediction for if_pc (combinational)
redirect_valid  out  1  one-cycle pulse: refetch from redirect_pc, flush IF/ID
redirect_pc  out  XLEN  corrected fetch address
perf_branches  out  32  resolved-control-transfer count (see Optional Feature)
perf_mispredicts  out  32  mispredict count (see Optional Feature)

Behaviour:
- Reset (async assert, sync-safe deassert): all BHT entries = 2'b01 (weakly not-taken); redirect_valid=0; redirect_pc=0; perf counters=0.
- Lookup: if_pred_taken = BHT[if_pc idx][1]; purely combinational.
  - Same-cycle update to the same index is NOT bypassed; lookup returns the pre-update value.
- Resolve condition: ex_valid & ~stall & ~redirect_valid & (ex_is_branch | ex_is_jal | ex_is_jalr).
  - The ~redirect_valid term squashes the wrong-path shadow instruction in the cycle after a redirect.
- Actual taken:
  - Branch: cmp_result.
  - JAL/JALR: 1.
- Actual next PC:
  - Taken branch or JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1+ex_imm) & ~32'h1.
  - Not-taken branch: ex_pc+4.
  - All adds are modulo 2^32; wrap-around is legal, no exception.
- Mispredict: actual_next_pc != ex_pred_target. This covers both direction and target errors.
- On resolve with mispredict: next cycle redirect_valid=1 and redirect_pc=actual_next_pc, for exactly one cycle.
  - Latency: 1 cycle, registered output.
- On resolve without mispredict: redirect_valid=0 next cycle.
- BHT update: only on a resolved conditional branch, at the same edge as the redirect register.
  - Taken: saturating increment, 11 stays 11.
  - Not taken: saturating decrement, 00 stays 00.
  - JAL/JALR never update the BHT.
- stall=1: no BHT update, no counter update.
  - A redirect already asserted still drops after its one cycle; fetch unit must accept the redirect during stall.
- Reset mid-operation: pending redirect is cancelled immediately; BHT is reinitialised.
- Multiple type flags set simultaneously is illegal. Assertion fires in simulation; priority is jalr > jal > branch.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - perf_branches increments on every resolve.
  - perf_mispredicts increments on every resolve that mispredicts.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: counters are not built; both outputs are tied to 0. Ports remain so the top level is unchanged.

Test Plan:
- Reset, then if_pc=0x40 -> if_pred_taken=0. Any PC also returns 0 (all entries 01).
- BEQ at pc=0x100, imm=0x20, cmp_result=1, pred_taken=0, pred_target=0x104:
  - Next cycle redirect_valid=1, redirect_pc=0x120.
  - BHT[0x100] becomes 10; if_pc=0x100 now predicts taken.
- JALR with ex_rs1=0x2003, imm=0x4, pred_target=0x2006 -> no redirect (target 0x2006). Same with pred_target=0x2000 -> redirect_pc=0x2006; BHT unchanged.
- Back-to-back mispredicts: mispredicting branch in cycle N, second mispredicting branch presented in N+1 -> second is squashed, no redirect in N+2, no BHT update.
- Saturation: resolve the same branch taken 4 times -> entry=11, stays 11. Resolve not-taken once -> 10, prediction still taken.
- Wrap and stall:
  - ex_pc=0xFFFF_FFF0, imm=0x20, taken -> redirect_pc=0x0000_0010.
  - Same stimulus with stall=1 -> no redirect, BHT and perf counters unchanged.
  - With BRU_PERF_CNT_EN: counters match resolve/mispredict totals.
